// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with a configurable frame format and a transmit FIFO.
// Queued frames go out back-to-back with no idle clock between them.
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   in_valid     - producer has a byte on in_data
//   in_data      - byte to transmit (DATA_BITS wide)
//   in_ready     - combinational; FIFO not full
//   tx           - serial line, idle high
//   busy         - high while any frame bit is on the line
//   tx_done      - one-cycle pulse on the final clock of each frame's last stop bit
//   fifo_count   - current FIFO occupancy
module uart_tx_fifo #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned BAUD       = 115_200,
  parameter int unsigned BAUD_DIV   = CLK_HZ / BAUD,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(BAUD_DIV);
  localparam int unsigned BIT_W  = $clog2(DATA_BITS + 1);

  // Elaboration-time parameter checks
  if (BAUD == 0 || CLK_HZ < BAUD) begin : g_bad_rate
    $error("uart_tx_fifo: CLK_HZ must be >= BAUD and BAUD non-zero");
  end
  if (BAUD_DIV < 2) begin : g_bad_div
    $error("uart_tx_fifo: BAUD_DIV must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_fifo: DATA_BITS must be 5..9");
  end
  if (PARITY > 2) begin : g_bad_par
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e               state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];

  logic push_c, pop_c, baud_end_c, last_stop_c;
  logic [DATA_BITS-1:0] head_c;

  assign in_ready    = (count_q != CNT_W'(FIFO_DEPTH));
  assign push_c      = in_valid && in_ready;
  assign baud_end_c  = (baud_q == '0);
  assign last_stop_c = (state_q == S_STOP) && (bit_q == BIT_W'(STOP_BITS - 1));
  assign head_c      = mem_q[rd_ptr_q];
  // A new frame starts from idle, or on the final clock of the previous frame
  assign pop_c       = (count_q != '0) &&
                       ((state_q == S_IDLE) || (last_stop_c && baud_end_c));

  // FIFO storage; contents need no reset
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_c) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop_c) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push_c, pop_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencer: next state and line outputs
  always_comb begin
    state_d = state_q;
    baud_d  = baud_end_c ? baud_q : baud_q - BAUD_W'(1);
    bit_d   = bit_q;
    shreg_d = shreg_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end
      S_START: begin
        if (baud_end_c) begin
          state_d = S_DATA;
          baud_d  = BAUD_W'(BAUD_DIV - 1);
          bit_d   = '0;
          tx_d    = shreg_q[0];
          shreg_d = shreg_q >> 1;
        end
      end
      S_DATA: begin
        if (baud_end_c) begin
          baud_d = BAUD_W'(BAUD_DIV - 1);
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            bit_d = '0;
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            tx_d    = shreg_q[0];
            shreg_d = shreg_q >> 1;
          end
        end
      end
      S_PARITY: begin
        if (baud_end_c) begin
          state_d = S_STOP;
          baud_d  = BAUD_W'(BAUD_DIV - 1);
          bit_d   = '0;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        // Registered pulse lands on the last clock of the last stop bit
        if (last_stop_c && baud_q == BAUD_W'(1)) begin
          done_d = 1'b1;
        end
        if (baud_end_c) begin
          if (last_stop_c) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end else begin
            bit_d  = bit_q + BIT_W'(1);
            baud_d = BAUD_W'(BAUD_DIV - 1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Pop overrides the idle/stop decisions above and starts a fresh frame
    if (pop_c) begin
      state_d = S_START;
      baud_d  = BAUD_W'(BAUD_DIV - 1);
      bit_d   = '0;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      shreg_d = head_c;
      par_d   = (PARITY == 1) ? ~^head_c : ^head_c;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign tx_done    = done_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (8N1 depth 4, 7E2, 8O1) at 10 clocks per bit,
// compared every cycle against a frame-timeline model built from queues.
module tb_uart_tx_fifo;

  localparam int BD = 10;
  localparam int NI = 3;

  function automatic int db(input int i);  return (i == 1) ? 7 : 8; endfunction
  function automatic int par(input int i); return (i == 0) ? 0 : ((i == 1) ? 2 : 1); endfunction
  function automatic int sb(input int i);  return (i == 1) ? 2 : 1; endfunction
  function automatic int dep(input int i); return (i == 0) ? 4 : 16; endfunction
  function automatic int flen(input int i);
    return (1 + db(i) + ((par(i) != 0) ? 1 : 0) + sb(i)) * BD;
  endfunction

  // Line bits of one frame, bit k = k-th bit period on the wire
  function automatic logic [15:0] frame_bits(input int i, input int d);
    logic [15:0] f;
    int k, ones, dm;
    dm = d & ((1 << db(i)) - 1);
    f = '0; k = 1; ones = 0;
    for (int b = 0; b < db(i); b++) begin
      f[k] = dm[b];
      ones += int'(dm[b]);
      k++;
    end
    if (par(i) == 1) begin f[k] = ((ones % 2) == 0); k++; end
    else if (par(i) == 2) begin f[k] = ((ones % 2) == 1); k++; end
    for (int s = 0; s < sb(i); s++) begin f[k] = 1'b1; k++; end
    return f;
  endfunction

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vin [NI];
  logic [8:0] din [NI];
  logic       rdy [NI];
  logic       txo [NI];
  logic       bsy [NI];
  logic       dn  [NI];
  logic [4:0] cnt [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned DBG = db(g);
    localparam int unsigned CW  = $clog2(dep(g)) + 1;
    logic [DBG-1:0] d_l;
    logic [CW-1:0]  c_l;
    assign d_l    = din[g][DBG-1:0];
    assign cnt[g] = 5'(c_l);
    uart_tx_fifo #(
      .CLK_HZ(1_000_000), .BAUD(100_000), .DATA_BITS(DBG),
      .PARITY(par(g)), .STOP_BITS(sb(g)), .FIFO_DEPTH(dep(g))
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(vin[g]), .in_data(d_l),
      .in_ready(rdy[g]), .tx(txo[g]), .busy(bsy[g]), .tx_done(dn[g]),
      .fifo_count(c_l)
    );
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: accepted-byte queue plus position inside the current frame
  int          mq [NI][$];
  bit          mbusy [NI];
  int          mt [NI];
  logic [15:0] mfr [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NI; i++) begin
        mq[i].delete();
        mbusy[i] = 1'b0;
        mt[i] = 0;
      end
    end else begin
      for (int i = 0; i < NI; i++) begin
        bit push, start;
        int pd;
        push  = vin[i] && (mq[i].size() != dep(i));
        pd    = int'(din[i]) & ((1 << db(i)) - 1);
        start = 1'b0;
        if (mbusy[i]) begin
          if (mt[i] == flen(i) - 1) begin
            if (mq[i].size() > 0) start = 1'b1;
            else mbusy[i] = 1'b0;
          end else begin
            mt[i]++;
          end
        end else if (mq[i].size() > 0) begin
          start = 1'b1;
        end
        if (start) begin
          mfr[i]   = frame_bits(i, mq[i].pop_front());
          mt[i]    = 0;
          mbusy[i] = 1'b1;
        end
        if (push) mq[i].push_back(pd);
      end
    end
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      logic etx;
      etx = mbusy[i] ? mfr[i][mt[i] / BD] : 1'b1;
      chk($sformatf("tx%0d", i), 32'(txo[i]), 32'(etx));
      chk($sformatf("busy%0d", i), 32'(bsy[i]), 32'(mbusy[i]));
      chk($sformatf("tx_done%0d", i), 32'(dn[i]), 32'(mbusy[i] && (mt[i] == flen(i) - 1)));
      chk($sformatf("fifo_count%0d", i), 32'(cnt[i]), 32'(mq[i].size()));
      chk($sformatf("in_ready%0d", i), 32'(rdy[i]), 32'(mq[i].size() != dep(i)));
    end
  end

  // Running statistics for the literal scenario checks
  int busy_tot [NI], done_tot [NI], txlow_tot [NI], cur_run [NI], last_run [NI], peak [NI];

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (bsy[i] === 1'b1) begin
        busy_tot[i]++;
        cur_run[i]++;
      end else begin
        if (cur_run[i] > 0) last_run[i] = cur_run[i];
        cur_run[i] = 0;
      end
      if (dn[i] === 1'b1) done_tot[i]++;
      if (txo[i] === 1'b0) txlow_tot[i]++;
      if (int'(cnt[i]) > peak[i]) peak[i] = int'(cnt[i]);
    end
  end

  int base_done [NI];
  int base_busy [NI];
  int base_low  [NI];

  task automatic snap();
    for (int i = 0; i < NI; i++) begin
      base_done[i] = done_tot[i];
      base_busy[i] = busy_tot[i];
      base_low[i]  = txlow_tot[i];
    end
  endtask

  function automatic bit any_active();
    bit a;
    a = 1'b0;
    for (int i = 0; i < NI; i++) if (bsy[i] !== 1'b0 || cnt[i] !== 5'd0) a = 1'b1;
    return a;
  endfunction

  initial begin
    logic [7:0] bytes [6];
    int k, cyc, acc5, w;
    logic r;

    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin vin[i] = 1'b0; din[i] = '0; end

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_tx%0d", i), 32'(txo[i]), 32'd1);
      chk($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'd0);
      chk($sformatf("rst_cnt%0d", i), 32'(cnt[i]), 32'd0);
      chk($sformatf("rst_ready%0d", i), 32'(rdy[i]), 32'd1);
    end
    @(posedge clk); #3 rst_n = 1'b1;

    // Hand-computed frames pin the model
    chk("pin_8n1_55", 32'(frame_bits(0, 'h55)), 32'h02AA);
    chk("pin_7e2_41", 32'(frame_bits(1, 'h41)), 32'h0682);
    chk("pin_8o1_00", 32'(frame_bits(2, 'h00)), 32'h0600);
    chk("pin_8o1_ff", 32'(frame_bits(2, 'hFF)), 32'h07FE);
    chk("pin_len_8n1", 32'(flen(0)), 32'd100);
    chk("pin_len_7e2", 32'(flen(1)), 32'd110);

    // Single frames on each format; two back-to-back on 8O1
    @(posedge clk);
    snap();
    #1;
    vin[0] = 1'b1; din[0] = 9'h055;
    vin[1] = 1'b1; din[1] = 9'h041;
    vin[2] = 1'b1; din[2] = 9'h000;
    @(posedge clk); #1;
    vin[0] = 1'b0; vin[1] = 1'b0; din[2] = 9'h0FF;
    @(negedge clk);
    chk("lat_tx_hold", 32'(txo[0]), 32'd1);
    chk("lat_cnt_one", 32'(cnt[0]), 32'd1);
    @(posedge clk); #1;
    vin[2] = 1'b0;
    @(negedge clk);
    chk("lat_tx_fall", 32'(txo[0]), 32'd0);
    chk("lat_cnt_zero", 32'(cnt[0]), 32'd0);
    repeat (240) @(posedge clk);
    chk("run_8n1", 32'(last_run[0]), 32'd100);
    chk("run_7e2", 32'(last_run[1]), 32'd110);
    chk("run_8o1_pair", 32'(last_run[2]), 32'd220);
    chk("done_8n1", 32'(done_tot[0] - base_done[0]), 32'd1);
    chk("done_7e2", 32'(done_tot[1] - base_done[1]), 32'd1);
    chk("done_8o1", 32'(done_tot[2] - base_done[2]), 32'd2);
    chk("busy_8n1", 32'(busy_tot[0] - base_busy[0]), 32'd100);

    // Depth-4 FIFO with in_valid held over six bytes, then 0xAA offered while full
    for (int j = 0; j < 6; j++) bytes[j] = 8'(8'h10 + 8'h11 * j);
    snap();
    k = 0; cyc = 0; acc5 = 0;
    @(posedge clk); #1;
    vin[0] = 1'b1; din[0] = 9'(bytes[0]);
    while (k < 6 && cyc < 2000) begin
      @(negedge clk);
      r = rdy[0];
      @(posedge clk);
      cyc++;
      if (r === 1'b1) begin
        k++;
        if (cyc <= 5) acc5++;
      end
      #1;
      if (k < 6) din[0] = 9'(bytes[k]);
      else vin[0] = 1'b0;
    end
    chk("depth_all_accepted", 32'(k), 32'd6);
    chk("depth_accept_by5", 32'(acc5), 32'd5);
    chk("depth_peak", 32'(peak[0]), 32'd4);
    vin[0] = 1'b1; din[0] = 9'h0AA;
    repeat (50) @(posedge clk);
    #1 vin[0] = 1'b0;
    @(negedge clk);
    chk("full_cnt_held", 32'(cnt[0]), 32'd4);
    w = 0;
    while ((bsy[0] !== 1'b0 || cnt[0] !== 3'd0) && w < 1000) begin
      @(negedge clk);
      w++;
    end
    chk("depth_drain_timeout", 32'(w < 1000), 32'd1);
    @(posedge clk);
    chk("depth_run", 32'(last_run[0]), 32'd600);
    chk("depth_done", 32'(done_tot[0] - base_done[0]), 32'd6);

    // Randomized traffic on all three formats
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NI; i++) begin
        vin[i] = ($urandom_range(0, 7) == 0);
        din[i] = 9'($urandom_range(0, 511));
      end
    end
    @(posedge clk); #1;
    for (int i = 0; i < NI; i++) vin[i] = 1'b0;
    w = 0;
    while (any_active() && w < 3000) begin
      @(negedge clk);
      w++;
    end
    chk("rand_drain_timeout", 32'(w < 3000), 32'd1);

    // Asynchronous reset during data bit 3 with two bytes queued
    @(posedge clk); #1;
    vin[0] = 1'b1; din[0] = 9'h0F0;
    @(posedge clk); #1 din[0] = 9'h00F;
    @(posedge clk); #1 din[0] = 9'h033;
    @(posedge clk); #1 vin[0] = 1'b0;
    repeat (40) @(posedge clk);
    #3;
    chk("pre_rst_tx_low", 32'(txo[0]), 32'd0);
    chk("pre_rst_cnt", 32'(cnt[0]), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_tx", 32'(txo[0]), 32'd1);
    chk("async_rst_busy", 32'(bsy[0]), 32'd0);
    chk("async_rst_cnt", 32'(cnt[0]), 32'd0);
    chk("async_rst_ready", 32'(rdy[0]), 32'd1);
    snap();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (300) @(posedge clk);
    chk("post_rst_done", 32'(done_tot[0] - base_done[0]), 32'd0);
    chk("post_rst_busy", 32'(busy_tot[0] - base_busy[0]), 32'd0);
    chk("post_rst_tx_low", 32'(txlow_tot[0] - base_low[0]), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter. It has a configurable frame format (data bits, parity, stop bits) and an internal transmit FIFO with a valid/ready input handshake. It replaces the fixed 8-N-1 single-byte transmitter as the serial output stage for game-state and debug messages. Producers push bytes without waiting for each frame to finish, and queued frames go out back-to-back.

Parameters:
CLK_HZ, 100_000_000, system clock frequency in Hz
BAUD, 115_200, line rate in bit/s
BAUD_DIV, CLK_HZ/BAUD, clocks per bit; must be >= 2; 868 at defaults
DATA_BITS, 8, data bits per frame; legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame; 1 or 2
FIFO_DEPTH, 16, FIFO entries; power of two, >= 2

Ports:
clk  in  1  system clock, all logic on rising edge
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  producer has a byte on in_data
in_data  in  DATA_BITS  byte to transmit
in_ready  out  1  FIFO can accept; combinational, equals (fifo_count != FIFO_DEPTH)
tx  out  1  serial line, idle high
busy  out  1  high while any frame bit is on the line
tx_done  out  1  one-cycle pulse at the end of each frame's last stop bit
fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset (rst_n low, asynchronous):
  - tx=1, busy=0, tx_done=0, fifo_count=0, in_ready=1.
  - FIFO pointers cleared, FSM to IDLE, bit counter and baud counter zeroed.
  - Reset mid-frame: line returns high immediately; frame and queued data are discarded.
- Push: occurs on an edge where in_valid && in_ready. in_valid while full is ignored; no overrun flag.
- Pop: the FSM pops on an edge where it is in IDLE (or finishing the last stop bit) and the FIFO is non-empty.
- Push and pop on the same edge: fifo_count unchanged. When full, in_ready stays low even if a pop occurs that cycle.
- FIFO:
  - Circular buffer; read/write pointers wrap at FIFO_DEPTH.
  - Output order equals input order.
  - Storage need not be reset.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1, busy=0. If non-empty: pop, load shift register, go to START. tx=0 and busy=1 from that same edge.
  - START: lasts BAUD_DIV clocks, then DATA.
  - DATA: DATA_BITS bits, LSB first, BAUD_DIV clocks each. Then PARITY if PARITY!=0, else STOP.
  - PARITY: one bit. Odd = ~^data (total ones incl. parity odd). Even = ^data.
  - STOP: STOP_BITS bits of 1, BAUD_DIV clocks each.
    - At end of the last stop bit, tx_done pulses for one cycle.
    - If FIFO non-empty: pop and enter START on that same edge. No idle clock between frames; busy stays high.
    - Else: go to IDLE, busy=0.
- Latency: byte accepted at edge N into an empty FIFO with FSM in IDLE → tx falls at edge N+1.
- Frame length is exactly (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*BAUD_DIV clocks.
- Baud counter:
  - Width $clog2(BAUD_DIV).
  - Loads BAUD_DIV-1 at each bit start and decrements to 0.
  - Bit advance happens on the 0 cycle.
- Illegal parameter values are rejected at elaboration (generate-time error).

Test Plan:
Bench parameters: CLK_HZ=1_000_000, BAUD=100_000 (BAUD_DIV=10) unless noted.
- 8N1, push 0x55 once → tx falls the cycle after accept; bits 0,1,0,1,0,1,0,1,0,1 at 10 clocks each; busy high for 100 clocks; one tx_done on the final cycle; tx stays 1 afterwards.
- DATA_BITS=7, PARITY=2, STOP_BITS=2, push 0x41 → start, 1,0,0,0,0,0,1, parity 0, 1, 1; frame exactly 110 clocks.
- PARITY=1, push 0x00 → parity bit 1; push 0xFF → parity bit 1; frames 110 clocks each, back-to-back.
- FIFO_DEPTH=4, in_valid held with 6 distinct bytes → 5 accepted by cycle 5, fifo_count peaks at 4, in_ready low until the first frame's pop. All 6 bytes transmitted in order over 600 contiguous busy clocks with no idle gap; 6 tx_done pulses.
- Full FIFO, in_valid with 0xAA while in_ready low → 0xAA never appears on tx; fifo_count unchanged.
- rst_n low during data bit 3 of a frame with 2 more queued → tx=1, busy=0, fifo_count=0 without waiting for a clock edge. After release, tx stays idle and no tx_done occurs.
